// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI responder.
//   - byte-wide APB register addresses
//   - CTRL / STATUS bit positions
//   - responder FSM state encoding
`timescale 1ns/1ps
package spi_pkg;

  localparam logic [7:0] ADDR_RX_INSTR = 8'h00;
  localparam logic [7:0] ADDR_RX_BYTE1 = 8'h01;
  localparam logic [7:0] ADDR_RX_BYTE5 = 8'h05;
  localparam logic [7:0] ADDR_RX_CNT   = 8'h06;
  localparam logic [7:0] ADDR_CTRL     = 8'h07;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_TX_BYTE1 = 8'h09;
  localparam logic [7:0] ADDR_TX_BYTE5 = 8'h0D;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_CLR_DONE  = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_PARTIAL   = 3;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings one asynchronous SPI pin into the pclk domain.
//   pclk_i, presetn_i : clock / async active-low reset
//   async_i           : raw pin
//   sync_o            : synchronized level (SYNC_STAGES flops)
//   rise_o / fall_o   : one-cycle pulses from the extra edge-detect flop
// Everything resets to 0 so that a pin already low at reset release never
// looks like a falling edge (a held-low cs must be released first).
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk_i,
  input  logic presetn_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_reg[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_reg;
  assign fall_o = ~sync_o & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with an APB register file.
//   pclk_i, presetn_i          : clock (also SPI oversampling) / async active-low reset
//   paddr_i, psel_i, penable_i,
//   pwrite_i, pwdata_i         : APB request
//   prdata_o (registered), pready_o (always 1), pslverr_o : APB response
//   sclk_i, cs_i, mosi_i       : SPI inputs, cs active low, asynchronous
//   miso_o                     : SPI output, registered, 0 outside a frame
//   irq_o                      : frame-done interrupt (done & irq_en)
// Receives an instruction byte plus up to MAX_BYTES data bytes and shifts
// the pre-loaded TX bytes out one byte behind the received stream.
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int MAX_BYTES   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk_i,
  input  logic       presetn_i,
  input  logic [7:0] paddr_i,
  input  logic       psel_i,
  input  logic       penable_i,
  input  logic       pwrite_i,
  input  logic [7:0] pwdata_i,
  output logic [7:0] prdata_o,
  output logic       pready_o,
  output logic       pslverr_o,
  input  logic       sclk_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       irq_o
);

  localparam logic [2:0] LAST_IDX = 3'(MAX_BYTES);

  // Input conditioning: bit 0 sclk, bit 1 cs, bit 2 mosi
  logic [2:0] spi_raw, spi_lvl, spi_rise, spi_fall;
  assign spi_raw = {mosi_i, cs_i, sclk_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .pclk_i   (pclk_i),
      .presetn_i(presetn_i),
      .async_i  (spi_raw[gi]),
      .sync_o   (spi_lvl[gi]),
      .rise_o   (spi_rise[gi]),
      .fall_o   (spi_fall[gi])
    );
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  assign sclk_rise = spi_rise[0];
  assign sclk_fall = spi_fall[0];
  assign cs_rise   = spi_rise[1];
  assign cs_fall   = spi_fall[1];
  assign mosi_sync = spi_lvl[2];

  // State
  spi_state_e state_reg, state_next;
  logic       ctrl_en_reg, irq_en_reg;
  logic       busy_reg, done_reg, ovf_reg, part_reg;
  logic [2:0] bit_cnt_reg, byte_idx_reg;
  logic [7:0] rx_sr_reg, tx_sr_reg, prdata_reg;
  logic       miso_reg;
  logic [7:0] rx_mem_reg [0:MAX_BYTES];
  logic [7:0] tx_mem_reg [1:MAX_BYTES];

  // FSM
  logic frame_start, frame_end;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) state_reg <= S_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_reg)
      S_IDLE: if (cs_fall && ctrl_en_reg) begin
        frame_start = 1'b1;
        state_next  = S_ACTIVE;
      end
      S_ACTIVE: if (cs_rise) begin
        frame_end  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte assembled on this sclk rise, and the response byte for the next slot
  logic [7:0] rx_byte, tx_next_byte;
  assign rx_byte = {rx_sr_reg[6:0], mosi_sync};

  always_comb begin
    tx_next_byte = 8'h00;
    for (int i = 1; i <= MAX_BYTES; i++) begin
      if (byte_idx_reg + 3'd1 == 3'(i)) tx_next_byte = tx_mem_reg[i];
    end
  end

  // APB decode
  logic is_ctrl, is_tx, apb_wr, wr_err, wr_ok;
  logic [7:0] rd_data;

  assign is_ctrl   = (paddr_i == ADDR_CTRL);
  assign is_tx     = (paddr_i >= ADDR_TX_BYTE1) && (paddr_i <= ADDR_TX_BYTE5);
  assign apb_wr    = psel_i & penable_i & pwrite_i;
  // TX bytes are frozen while a frame is shifting them out
  assign wr_err    = ~(is_ctrl | is_tx) | (is_tx & busy_reg);
  assign wr_ok     = apb_wr & ~wr_err;
  assign pslverr_o = apb_wr & wr_err;
  assign pready_o  = 1'b1;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i <= MAX_BYTES; i++) begin
      if (paddr_i == ADDR_RX_INSTR + 8'(i)) rd_data = rx_mem_reg[i];
    end
    for (int i = 1; i <= MAX_BYTES; i++) begin
      if (paddr_i == ADDR_TX_BYTE1 + 8'(i - 1)) rd_data = tx_mem_reg[i];
    end
    case (paddr_i)
      ADDR_RX_CNT: rd_data = {5'b0, byte_idx_reg};
      ADDR_CTRL: begin
        rd_data[CTRL_EN]     = ctrl_en_reg;
        rd_data[CTRL_IRQ_EN] = irq_en_reg;
      end
      ADDR_STATUS: begin
        rd_data[STAT_BUSY]     = busy_reg;
        rd_data[STAT_DONE]     = done_reg;
        rd_data[STAT_OVERFLOW] = ovf_reg;
        rd_data[STAT_PARTIAL]  = part_reg;
      end
      default: ;
    endcase
  end

  // Read data is captured in the setup phase so it is stable in the access phase
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i)                prdata_reg <= 8'h00;
    else if (psel_i && !penable_i) prdata_reg <= rd_data;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      for (int i = 1; i <= MAX_BYTES; i++) tx_mem_reg[i] <= 8'h00;
    end else if (wr_ok && is_tx) begin
      for (int i = 1; i <= MAX_BYTES; i++) begin
        if (paddr_i == ADDR_TX_BYTE1 + 8'(i - 1)) tx_mem_reg[i] <= pwdata_i;
      end
    end
  end

  // Control, status and frame datapath
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      ctrl_en_reg  <= 1'b0;
      irq_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      part_reg     <= 1'b0;
      bit_cnt_reg  <= 3'd0;
      byte_idx_reg <= 3'd0;
      rx_sr_reg    <= 8'h00;
      tx_sr_reg    <= 8'h00;
      miso_reg     <= 1'b0;
      for (int i = 0; i <= MAX_BYTES; i++) rx_mem_reg[i] <= 8'h00;
    end else begin
      if (wr_ok && is_ctrl) begin
        ctrl_en_reg <= pwdata_i[CTRL_EN];
        irq_en_reg  <= pwdata_i[CTRL_IRQ_EN];
        if (pwdata_i[CTRL_CLR_DONE]) done_reg <= 1'b0;
      end
      // Frame events come after the clear so a coincident frame end leaves done set
      if (frame_start) begin
        bit_cnt_reg  <= 3'd0;
        byte_idx_reg <= 3'd0;
        tx_sr_reg    <= 8'h00;
        miso_reg     <= 1'b0;
        busy_reg     <= 1'b1;
        done_reg     <= 1'b0;
        ovf_reg      <= 1'b0;
        part_reg     <= 1'b0;
      end else if (frame_end) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
        part_reg <= (bit_cnt_reg != 3'd0);
        miso_reg <= 1'b0;
      end else if (state_reg == S_ACTIVE) begin
        if (sclk_rise) begin
          rx_sr_reg   <= rx_byte;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (byte_idx_reg <= LAST_IDX) begin
              for (int i = 0; i <= MAX_BYTES; i++) begin
                if (byte_idx_reg == 3'(i)) rx_mem_reg[i] <= rx_byte;
              end
              byte_idx_reg <= byte_idx_reg + 3'd1;
              tx_sr_reg    <= tx_next_byte;
            end else begin
              // Byte beyond the register map: flag it, keep nothing
              ovf_reg <= 1'b1;
            end
          end
        end
        if (sclk_fall) begin
          miso_reg  <= tx_sr_reg[7];
          tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
        end
      end
    end
  end

  assign prdata_o = prdata_reg;
  assign miso_o   = miso_reg;
  assign irq_o    = done_reg & irq_en_reg;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 6;   // sclk half period in pclk cycles
  localparam int NREG = 14;  // addresses 0x00..0x0D

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata_o;
  logic       pready_o, pslverr_o;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso_o, irq_o;

  always #5 pclk = ~pclk;

  spi_slave dut (
    .pclk_i   (pclk),
    .presetn_i(presetn),
    .paddr_i  (paddr),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .pwdata_i (pwdata),
    .prdata_o (prdata_o),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o),
    .sclk_i   (sclk),
    .cs_i     (cs_n),
    .mosi_i   (mosi),
    .miso_o   (miso_o),
    .irq_o    (irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents as the bench expects them
  logic [7:0] rx_model [0:5];
  logic [7:0] tx_model [1:5];
  logic       irq_en_model;
  logic [7:0] fdata [0:15];

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    wait_clk(1);
    penable = 1'b1;
    #1;
    rdata = prdata_o;
    err   = pslverr_o;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, input logic exp_err);
    logic [7:0] d;
    logic       e;
    apb_xfer(1'b1, addr, data, d, e);
    check8($sformatf("pslverr_wr_%02h", addr), {7'b0, e}, {7'b0, exp_err});
    if (!exp_err && addr >= 8'h09 && addr <= 8'h0D) tx_model[int'(addr) - 8] = data;
    if (!exp_err && addr == 8'h07) irq_en_model = data[1];
  endtask

  task automatic apb_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    logic       e;
    apb_xfer(1'b0, addr, 8'h00, d, e);
    check8(tag, d, exp);
  endtask

  // Shift nbits of b (MSB first); returns MISO as sampled just before each rise
  task automatic spi_shift(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7 - i];
      wait_clk(HALF);
      got  = {got[6:0], miso_o};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  // One frame: nbytes full bytes from fdata, then extra bits of the next one.
  // mid_apb exercises the register interface while the frame is open.
  task automatic run_frame(input int nbytes, input int extra, input logic mid_apb);
    logic [7:0] got, exp, exp_st;
    int         stored;
    cs_n = 1'b0;
    wait_clk(HALF);
    if (mid_apb) begin
      apb_read(8'h08, 8'h01, "status_busy");
      apb_write(8'h09, ~tx_model[1], 1'b1);
      apb_read(8'h09, tx_model[1], "tx1_kept_busy");
    end
    for (int j = 0; j < nbytes; j++) begin
      spi_shift(fdata[j], 8, got);
      exp = (j >= 1 && j <= 5) ? tx_model[j] : 8'h00;
      check8($sformatf("miso_byte%0d", j), got, exp);
    end
    if (extra > 0) spi_shift(fdata[nbytes], extra, got);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2);
    check8("irq_before_done", {7'b0, irq_o}, 8'h00);
    wait_clk(1);
    check8("irq_at_done", {7'b0, irq_o}, {7'b0, irq_en_model});
    wait_clk(4);
    stored = (nbytes > 6) ? 6 : nbytes;
    for (int k = 0; k < stored; k++) rx_model[k] = fdata[k];
    exp_st = 8'h02;
    if (nbytes > 6) exp_st = exp_st | 8'h04;
    if (extra > 0)  exp_st = exp_st | 8'h08;
    for (int k = 0; k < 6; k++) apb_read(8'(k), rx_model[k], $sformatf("rx_reg%0d", k));
    apb_read(8'h06, 8'(stored), "rx_cnt");
    apb_read(8'h08, exp_st, "status");
    $display("frame: %0d bytes + %0d bits, instr 0x%02h, status exp 0x%02h",
             nbytes, extra, fdata[0], exp_st);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) rx_model[k] = 8'h00;
    for (int k = 1; k <= 5; k++) tx_model[k] = 8'h00;
    irq_en_model = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    model_reset();
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);

    // Reset state
    wait_clk(3);
    presetn = 1'b1;
    wait_clk(2);
    check8("miso_reset", {7'b0, miso_o}, 8'h00);
    check8("irq_reset", {7'b0, irq_o}, 8'h00);
    check8("pslverr_reset", {7'b0, pslverr_o}, 8'h00);
    check8("prdata_reset", prdata_o, 8'h00);
    check8("pready", {7'b0, pready_o}, 8'h01);
    for (int a = 0; a < NREG; a++) apb_read(8'(a), 8'h00, $sformatf("reset_reg%02h", a));

    apb_write(8'h07, 8'h01, 1'b0);

    // Instruction only
    fdata[0] = 8'hA5;
    run_frame(1, 0, 1'b0);

    // Full frame with known response bytes
    for (int k = 1; k <= 5; k++) apb_write(8'(8 + k), 8'(8'h11 * k), 1'b0);
    fdata[0] = 8'h03; fdata[1] = 8'hDE; fdata[2] = 8'hAD;
    fdata[3] = 8'hBE; fdata[4] = 8'hEF; fdata[5] = 8'h01;
    run_frame(6, 0, 1'b0);

    // Overflow: seven bytes, random data and responses
    for (int k = 1; k <= 5; k++) apb_write(8'(8 + k), 8'($urandom), 1'b0);
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
    run_frame(7, 0, 1'b0);

    // Partial: two bytes and three bits
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
    run_frame(2, 3, 1'b0);

    // APB errors: TX write mid-frame, RO write, unmapped write
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
    run_frame(1, 0, 1'b1);
    apb_write(8'h02, 8'h5A, 1'b1);
    apb_read(8'h02, rx_model[2], "ro_unchanged");
    apb_write(8'h20, 8'h5A, 1'b1);
    apb_read(8'h20, 8'h00, "unmapped_read");

    // Interrupt and clear_done
    apb_write(8'h07, 8'h03, 1'b0);
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
    run_frame(3, 0, 1'b0);
    check8("irq_held", {7'b0, irq_o}, 8'h01);
    apb_write(8'h07, 8'h07, 1'b0);
    check8("irq_cleared", {7'b0, irq_o}, 8'h00);
    apb_read(8'h08, 8'h00, "status_cleared");
    apb_read(8'h07, 8'h03, "ctrl_readback");

    // Random frames
    for (int f = 0; f < 6; f++) begin
      for (int k = 1; k <= 5; k++) apb_write(8'(8 + k), 8'($urandom), 1'b0);
      for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
      run_frame(int'($urandom_range(1, 8)), int'($urandom_range(0, 7)), 1'b0);
    end

    // Reset in the middle of a byte while MISO is driving ones
    apb_write(8'h09, 8'hFF, 1'b0);
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_shift(8'h3C, 8, got);
    spi_shift(8'hC3, 3, got);
    wait_clk(4);
    check8("miso_before_reset", {7'b0, miso_o}, 8'h01);
    presetn = 1'b0;
    #1;
    check8("miso_in_reset", {7'b0, miso_o}, 8'h00);
    check8("irq_in_reset", {7'b0, irq_o}, 8'h00);
    wait_clk(2);
    presetn = 1'b1;
    model_reset();
    wait_clk(2);
    for (int a = 0; a < NREG; a++) apb_read(8'(a), 8'h00, $sformatf("midreset_reg%02h", a));

    // cs still low after reset: enabling must not start a frame
    apb_write(8'h07, 8'h01, 1'b0);
    wait_clk(4);
    apb_read(8'h08, 8'h00, "no_frame_after_reset");
    cs_n = 1'b1;
    wait_clk(HALF);
    for (int j = 0; j < 16; j++) fdata[j] = 8'($urandom);
    run_frame(4, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
